// File: rtl/apb_rr_arbiter_if.sv
// Bundle of signals between two requesters, the arbiter and one APB slave.
//   req/wr/addr/wdata : per-requester request, direction and packed address/write data
//   ack/err/rdata     : per-requester completion/timeout pulses, shared read data
//   psel/penable/pwrite/paddr/pwdata : APB request side, driven by the arbiter
//   prdata/pready     : APB slave response
// modport master : the arbiter (APB master, serves the requesters)
// modport slave  : the environment (requesters plus the APB slave)
interface apb_rr_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic [1:0]          req;
    logic [1:0]          wr;
    logic [2*ADDR_W-1:0] addr;
    logic [2*DATA_W-1:0] wdata;
    logic [1:0]          ack;
    logic [1:0]          err;
    logic [DATA_W-1:0]   rdata;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [ADDR_W-1:0]   paddr;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W-1:0]   prdata;
    logic                pready;

    modport master (
        input  req, wr, addr, wdata, prdata, pready,
        output ack, err, rdata, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req, wr, addr, wdata, prdata, pready,
        input  ack, err, rdata, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// A granted transfer runs IDLE -> SETUP -> ACCESS and ends on pready (ack pulse)
// or after TIMEOUT consecutive wait edges (err pulse). All outputs are registered.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : apb_rr_arbiter_if.master (requester side and APB side)
module apb_rr_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input logic             clk,
    input logic             reset,
    apb_rr_arbiter_if.master bus
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    // Last wait edge before giving up; counter holds the number of wait edges seen so far.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e            state_q;
    logic              last_q;
    logic              gnt_q;
    logic [7:0]        cnt_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [1:0]        ack_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata_q;

    logic winner;

    // Single request wins outright; on a tie the requester not granted last wins.
    always_comb begin
        winner = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
        end else begin
            // Completion pulses last exactly one cycle.
            ack_q <= '0;
            err_q <= '0;
            case (state_q)
                StIdle: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    if (|bus.req) begin
                        gnt_q    <= winner;
                        last_q   <= winner;
                        pwrite_q <= bus.wr[winner];
                        paddr_q  <= winner ? bus.addr[2*ADDR_W-1:ADDR_W]
                                           : bus.addr[ADDR_W-1:0];
                        pwdata_q <= winner ? bus.wdata[2*DATA_W-1:DATA_W]
                                           : bus.wdata[DATA_W-1:0];
                        psel_q   <= 1'b1;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (bus.pready) begin
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        ack_q[gnt_q] <= 1'b1;
                        if (!pwrite_q) begin
                            rdata_q <= bus.prdata;
                        end
                        state_q <= StIdle;
                    end else if (cnt_q == CntLast) begin
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        err_q[gnt_q] <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.paddr   = paddr_q;
    assign bus.pwdata  = pwdata_q;
    assign bus.ack     = ack_q;
    assign bus.err     = err_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: directed scenarios followed by random
// transfers, checked against a transaction-level model of grant order, timing and rdata.
module tb_apb_rr_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    apb_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: who was granted last, and the visible read data.
    int          m_last;
    logic [DW-1:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer from the requester side. Entered at a negedge with the DUT idle.
    // waits = number of pready=0 edges the slave inserts before answering.
    // keep  = leave req asserted in the ack/err cycle for a back-to-back transfer.
    task automatic xfer(input logic [1:0] r, input logic [1:0] w,
                        input logic [2*AW-1:0] a, input logic [2*DW-1:0] d,
                        input int waits, input logic [DW-1:0] prd,
                        input bit keep, input string tag);
        int            win;
        bit            exp_ack;
        int            pen_cnt;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        bus.req    = r;
        bus.wr     = w;
        bus.addr   = a;
        bus.wdata  = d;
        bus.pready = 1'b0;
        bus.prdata = DW'($urandom);
        win     = (r == 2'b11) ? 1 - m_last : (r[1] ? 1 : 0);
        m_last  = win;
        ea      = a[win*AW +: AW];
        ed      = d[win*DW +: DW];
        ew      = w[win];
        exp_ack = (waits < int'(TO));

        @(negedge clk);
        chk({tag, "_setup_ctl"}, 32'({bus.psel, bus.penable}), 32'b10);
        chk({tag, "_setup_addr"}, 32'(bus.paddr), 32'(ea));
        chk({tag, "_setup_wr"}, 32'(bus.pwrite), 32'(ew));
        chk({tag, "_setup_wdata"}, 32'(bus.pwdata), 32'(ed));
        chk({tag, "_setup_pulse"}, 32'({bus.ack, bus.err}), 32'd0);
        // Requester side changes after grant must not disturb the transfer.
        bus.req   = 2'($urandom);
        bus.wr    = 2'($urandom);
        bus.addr  = (2*AW)'($urandom);
        bus.wdata = (2*DW)'($urandom);

        @(negedge clk);
        chk({tag, "_access_ctl"}, 32'({bus.psel, bus.penable}), 32'b11);
        pen_cnt = 1;
        for (int k = 0; k < int'(TO); k++) begin
            bus.pready = (k == waits);
            bus.prdata = (k == waits) ? prd : DW'($urandom);
            @(negedge clk);
            if (k == waits || k == int'(TO) - 1) break;
            chk({tag, "_wait_ctl"}, 32'({bus.psel, bus.penable, bus.ack, bus.err}), 32'b110000);
            chk({tag, "_wait_addr"}, 32'({bus.pwrite, bus.paddr, bus.pwdata}),
                32'({ew, ea, ed}));
            pen_cnt++;
        end
        bus.pready = 1'b0;
        bus.req    = keep ? r : 2'b00;
        if (exp_ack && !ew) m_rdata = prd;

        chk({tag, "_penable_cycles"}, 32'(pen_cnt), exp_ack ? 32'(waits + 1) : 32'(TO));
        chk({tag, "_end_ctl"}, 32'({bus.psel, bus.penable}), 32'd0);
        chk({tag, "_ack"}, 32'(bus.ack), exp_ack ? (32'd1 << win) : 32'd0);
        chk({tag, "_err"}, 32'(bus.err), exp_ack ? 32'd0 : (32'd1 << win));
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'(m_rdata));
        if (!keep) begin
            @(negedge clk);
            chk({tag, "_idle"}, 32'({bus.psel, bus.ack, bus.err}), 32'd0);
        end
    endtask

    initial begin
        reset      = 1'b0;
        bus.req    = '0;
        bus.wr     = '0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.prdata = '0;
        bus.pready = 1'b0;
        m_last     = 1;
        m_rdata    = '0;

        repeat (2) @(negedge clk);
        chk("rst_ctl", 32'({bus.psel, bus.penable, bus.pwrite}), 32'd0);
        chk("rst_paddr", 32'(bus.paddr), 32'd0);
        chk("rst_pwdata", 32'(bus.pwdata), 32'd0);
        chk("rst_pulse", 32'({bus.ack, bus.err}), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_no_req", 32'(bus.psel), 32'd0);

        // Zero-wait write from requester 0, then a 5-wait read from requester 1.
        xfer(2'b01, 2'b01, {8'h00, 8'h10}, {8'h00, 8'hA5}, 0, 8'h77, 1'b0, "w0");
        xfer(2'b10, 2'b00, {8'h22, 8'h00}, {8'h00, 8'h00}, 5, 8'h3C, 1'b0, "r1");

        // Both requesting continuously: grants alternate.
        for (int i = 0; i < 4; i++) begin
            xfer(2'b11, 2'($urandom), (2*AW)'($urandom), (2*DW)'($urandom),
                 $urandom_range(0, 2), DW'($urandom), i < 3, "rr");
        end

        // Slave never answers, then a normal transfer; then pready on the last allowed edge.
        xfer(2'b01, 2'b00, {8'h00, 8'h44}, {8'h00, 8'h00}, TO + 3, 8'h99, 1'b0, "tmo");
        xfer(2'b10, 2'b00, {8'h55, 8'h00}, {8'h00, 8'h00}, 1, 8'h5A, 1'b0, "after_tmo");
        xfer(2'b01, 2'b00, {8'h00, 8'h66}, {8'h00, 8'h00}, TO - 1, 8'hC3, 1'b0, "edge_rdy");

        // Reset while in ACCESS: everything drops at once and no pulse follows.
        bus.req  = 2'b10;
        bus.wr   = 2'b10;
        bus.addr = {8'h7E, 8'h00};
        @(negedge clk);
        @(negedge clk);
        chk("mid_access", 32'({bus.psel, bus.penable}), 32'b11);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'({bus.psel, bus.penable, bus.pwrite}), 32'd0);
        chk("mid_rst_bus", 32'({bus.paddr, bus.pwdata, bus.rdata}), 32'd0);
        chk("mid_rst_pulse", 32'({bus.ack, bus.err}), 32'd0);
        @(negedge clk);
        chk("mid_rst_hold", 32'({bus.psel, bus.ack, bus.err}), 32'd0);
        reset   = 1'b1;
        bus.req = 2'b00;
        m_last  = 1;
        m_rdata = '0;
        @(negedge clk);
        xfer(2'b11, 2'b00, {8'h21, 8'h12}, {8'h00, 8'h00}, 0, 8'hE1, 1'b0, "post_rst");

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            xfer(2'($urandom_range(1, 3)), 2'($urandom), (2*AW)'($urandom),
                 (2*DW)'($urandom), $urandom_range(0, TO + 2), DW'($urandom),
                 (i < 39) ? bit'($urandom_range(0, 1)) : 1'b0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
